// File: rtl/i2c_rx_pkg.sv
// Shared types and constants for the I2C receive-side shift/buffer logic.
package i2c_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    ACK_WAIT,
    ACK_DRIVE
  } rxState_t;

  localparam int unsigned BITS_PER_BYTE = 8;

  function automatic int unsigned bytesPerWord(input int unsigned wordW);
    return wordW / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/i2c_bus_sync_edge.sv
// Synchronizes raw SCL/SDA and derives sample/fall edges plus START/STOP conditions.
module i2c_bus_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic SCLIn,
  input  logic SDAIn,
  output logic sclS,
  output logic sdaS,
  output logic sampleEdge,
  output logic fallEdge,
  output logic startDet,
  output logic stopDet
);

  logic [SYNC_STAGES-1:0] sclSync;
  logic [SYNC_STAGES-1:0] sdaSync;
  logic                   sclPrev;
  logic                   sdaPrev;

  // Reset to the idle-bus level so releasing reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], SCLIn};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], SDAIn};
      sclPrev <= sclSync[SYNC_STAGES-1];
      sdaPrev <= sdaSync[SYNC_STAGES-1];
    end
  end

  assign sclS       = sclSync[SYNC_STAGES-1];
  assign sdaS       = sdaSync[SYNC_STAGES-1];
  assign sampleEdge = sclS & ~sclPrev;
  assign fallEdge   = ~sclS & sclPrev;
  assign startDet   = sclS & sclPrev & sdaPrev & ~sdaS;
  assign stopDet    = sclS & sclPrev & ~sdaPrev & sdaS;

endmodule

// File: rtl/i2c_rx_shift.sv
// I2C data-phase receiver: MSB-first shift, per-byte ACK/NACK, and ping-pong
// word buffers handed to the core over a valid/ready handshake.
module i2c_rx_shift
  import i2c_rx_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLIn,
  input  logic              SDAIn,
  output logic              SdaPullLow,
  output logic [WORD_W-1:0] RxOut,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              BusBusy,
  output logic              Overflow,
  output logic              FrameErr
);

  localparam int unsigned BYTES = bytesPerWord(WORD_W);
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic sclS, sdaS, sampleEdge, fallEdge, startDet, stopDet;

  i2c_bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk       (clk),
    .reset     (reset),
    .SCLIn     (SCLIn),
    .SDAIn     (SDAIn),
    .sclS      (sclS),
    .sdaS      (sdaS),
    .sampleEdge(sampleEdge),
    .fallEdge  (fallEdge),
    .startDet  (startDet),
    .stopDet   (stopDet)
  );

  rxState_t                 state, stateNext;
  logic [WORD_W-1:0]        shReg, shNext, shRestore;
  logic [BITS_PER_BYTE-1:0] topSave;
  logic [3:0]               bitCnt;
  logic [BCW-1:0]           byteCnt;
  logic [1:0]               full;
  logic [WORD_W-1:0]        bufMem [2];
  logic                     wrSel, rdSel, ackPending;
  logic                     partial, ackOk, lastByte, pop;
  logic                     newFrame, endFrame, frameErrNext;
  logic                     doShift, doDecide, driveAck, releaseAck;

  assign shNext    = {shReg[WORD_W-2:0], sdaS};
  assign shRestore = (shNext >> BITS_PER_BYTE) |
                     (WORD_W'(topSave) << (WORD_W - BITS_PER_BYTE));
  assign ackOk     = ~full[wrSel];
  assign lastByte  = (byteCnt == BCW'(BYTES - 1));
  assign RxValid   = full[rdSel];
  assign RxOut     = bufMem[rdSel];
  assign pop       = RxValid & RxReady;

  // The SCL rise that precedes a START/STOP is sampled as a bit; it only
  // counts toward a partial frame once SCL has fallen again.
  assign partial = (byteCnt != '0) || (bitCnt > 4'(sclS));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    newFrame     = 1'b0;
    endFrame     = 1'b0;
    frameErrNext = 1'b0;
    doShift      = 1'b0;
    doDecide     = 1'b0;
    driveAck     = 1'b0;
    releaseAck   = 1'b0;
    if (state == IDLE) begin
      if (startDet) begin
        stateNext = BIT;
        newFrame  = 1'b1;
      end
    end else if (stopDet) begin
      stateNext    = IDLE;
      endFrame     = 1'b1;
      frameErrNext = partial;
    end else if (startDet) begin
      stateNext    = BIT;
      newFrame     = 1'b1;
      frameErrNext = partial;
    end else begin
      case (state)
        BIT: begin
          if (sampleEdge) begin
            doShift = 1'b1;
            if (bitCnt == 4'(BITS_PER_BYTE - 1)) begin
              doDecide  = 1'b1;
              stateNext = ACK_WAIT;
            end
          end
        end
        ACK_WAIT: begin
          if (fallEdge) begin
            driveAck  = 1'b1;
            stateNext = ACK_DRIVE;
          end
        end
        ACK_DRIVE: begin
          if (fallEdge) begin
            releaseAck = 1'b1;
            stateNext  = BIT;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shReg      <= '0;
      topSave    <= '0;
      bitCnt     <= '0;
      byteCnt    <= '0;
      full       <= '0;
      bufMem[0]  <= '0;
      bufMem[1]  <= '0;
      wrSel      <= 1'b0;
      rdSel      <= 1'b0;
      ackPending <= 1'b0;
      SdaPullLow <= 1'b0;
      BusBusy    <= 1'b0;
      Overflow   <= 1'b0;
      FrameErr   <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      FrameErr <= frameErrNext;
      if (newFrame || endFrame) begin
        shReg      <= '0;
        bitCnt     <= '0;
        byteCnt    <= '0;
        SdaPullLow <= 1'b0;
        BusBusy    <= newFrame;
      end
      if (doShift) begin
        bitCnt <= bitCnt + 4'd1;
        if (bitCnt == '0) topSave <= shReg[WORD_W-1 -: BITS_PER_BYTE];
        shReg <= shNext;
      end
      if (doDecide) begin
        ackPending <= ackOk;
        if (!ackOk) begin
          Overflow <= 1'b1;
          shReg    <= shRestore;
        end else if (lastByte) begin
          bufMem[wrSel] <= shNext;
          full[wrSel]   <= 1'b1;
          wrSel         <= ~wrSel;
          byteCnt       <= '0;
        end else begin
          byteCnt <= byteCnt + BCW'(1);
        end
      end
      if (driveAck) SdaPullLow <= ackPending;
      if (releaseAck) begin
        SdaPullLow <= 1'b0;
        bitCnt     <= '0;
      end
      // Commit and pop never target the same buffer (commit needs it empty).
      if (pop) begin
        full[rdSel] <= 1'b0;
        rdSel       <= ~rdSel;
      end
    end
  end

endmodule

// File: tb/tb_i2c_rx_shift.sv
// Self-checking bench for i2c_rx_shift: bit-banged I2C master plus word scoreboard.
module tb_i2c_rx_shift;

  localparam int unsigned PH = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclDrv = 1'b1;
  logic        sdaDrv = 1'b1;
  logic        sdaLine;
  logic        SdaPullLow;
  logic [31:0] RxOut;
  logic        RxValid;
  logic        RxReady = 1'b1;
  logic        BusBusy;
  logic        Overflow;
  logic        FrameErr;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ovfCnt = 0;
  int unsigned ferrCnt = 0;
  logic [31:0] expQ [$];

  assign sdaLine = sdaDrv & ~SdaPullLow;

  always #5 clk = ~clk;

  i2c_rx_shift #(.WORD_W(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCLIn     (sclDrv),
    .SDAIn     (sdaLine),
    .SdaPullLow(SdaPullLow),
    .RxOut     (RxOut),
    .RxValid   (RxValid),
    .RxReady   (RxReady),
    .BusBusy   (BusBusy),
    .Overflow  (Overflow),
    .FrameErr  (FrameErr)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (Overflow) ovfCnt++;
    if (FrameErr) ferrCnt++;
    if (!reset && RxValid && RxReady) begin
      if (expQ.size() == 0) checkVal("popEmptyQueue", 32'(expQ.size()), 32'd1);
      else checkVal("rxWord", RxOut, expQ.pop_front());
    end
  end

  task automatic waitClk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setReady(input logic v);
    @(posedge clk);
    #1 RxReady = v;
  endtask

  task automatic sendBit(input logic b);
    sdaDrv = b;
    waitClk(PH);
    sclDrv = 1'b1;
    waitClk(PH);
    sclDrv = 1'b0;
    waitClk(2);
  endtask

  task automatic busStart();
    sdaDrv = 1'b1;
    sclDrv = 1'b1;
    waitClk(PH);
    sdaDrv = 1'b0;
    waitClk(PH);
    sclDrv = 1'b0;
    waitClk(PH);
  endtask

  task automatic busRepStart();
    sdaDrv = 1'b1;
    waitClk(PH);
    sclDrv = 1'b1;
    waitClk(PH);
    sdaDrv = 1'b0;
    waitClk(PH);
    sclDrv = 1'b0;
    waitClk(PH);
  endtask

  task automatic busStop();
    sdaDrv = 1'b0;
    waitClk(PH);
    sclDrv = 1'b1;
    waitClk(PH);
    sdaDrv = 1'b1;
    waitClk(PH);
  endtask

  task automatic sendByteBits(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    sdaDrv = 1'b1;
    waitClk(PH);
    sclDrv = 1'b1;
    waitClk(PH / 2);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic expAck);
    sendByteBits(d);
    checkVal("ackBit", 32'(SdaPullLow), 32'(expAck));
    waitClk(PH / 2);
    sclDrv = 1'b0;
    waitClk(2);
  endtask

  task automatic sendWord(input logic [31:0] w);
    expQ.push_back(w);
    for (int i = 3; i >= 0; i--) sendByte(w[i*8 +: 8], 1'b1);
  endtask

  initial begin
    int unsigned ferr0;
    int unsigned ovf0;

    waitClk(4);
    reset = 1'b0;
    waitClk(8);
    checkVal("rstSdaPullLow", 32'(SdaPullLow), 32'd0);
    checkVal("rstRxValid", 32'(RxValid), 32'd0);
    checkVal("rstRxOut", RxOut, 32'd0);
    checkVal("rstBusBusy", 32'(BusBusy), 32'd0);
    checkVal("rstOverflow", 32'(Overflow), 32'd0);
    checkVal("rstFrameErr", 32'(FrameErr), 32'd0);

    // Single word, consumer ready.
    ferr0 = ferrCnt;
    busStart();
    checkVal("busyAfterStart", 32'(BusBusy), 32'd1);
    sendWord(32'hA5C30F81);
    busStop();
    checkVal("busyAfterStop", 32'(BusBusy), 32'd0);
    checkVal("word1FrameErr", 32'(ferrCnt - ferr0), 32'd0);
    checkVal("word1Drained", 32'(expQ.size()), 32'd0);

    // Fill both buffers, then overflow one byte.
    setReady(1'b0);
    ovf0  = ovfCnt;
    ferr0 = ferrCnt;
    busStart();
    sendWord(32'h11223344);
    sendWord(32'h55667788);
    waitClk(4);
    checkVal("fullValid", 32'(RxValid), 32'd1);
    checkVal("fullHead", RxOut, 32'h11223344);
    sendByte(8'h99, 1'b0);
    busStop();
    checkVal("overflowPulses", 32'(ovfCnt - ovf0), 32'd1);
    checkVal("overflowNoFrameErr", 32'(ferrCnt - ferr0), 32'd0);
    checkVal("stillHead", RxOut, 32'h11223344);
    setReady(1'b1);
    waitClk(10);
    checkVal("bothPopped", 32'(expQ.size()), 32'd0);
    checkVal("emptyAfterPop", 32'(RxValid), 32'd0);

    // Short frame, then a clean word.
    ferr0 = ferrCnt;
    busStart();
    sendByte(8'hDE, 1'b1);
    sendByte(8'hAD, 1'b1);
    busStop();
    checkVal("shortFrameErr", 32'(ferrCnt - ferr0), 32'd1);
    checkVal("shortNoValid", 32'(RxValid), 32'd0);
    busStart();
    sendWord(32'h01020304);
    busStop();
    checkVal("afterShortFrameErr", 32'(ferrCnt - ferr0), 32'd1);
    checkVal("afterShortDrained", 32'(expQ.size()), 32'd0);

    // Repeated START mid-byte.
    ferr0 = ferrCnt;
    busStart();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    busRepStart();
    checkVal("repStartFrameErr", 32'(ferrCnt - ferr0), 32'd1);
    checkVal("repStartBusy", 32'(BusBusy), 32'd1);
    sendWord(32'hCAFEF00D);
    busStop();
    checkVal("repStartOneErr", 32'(ferrCnt - ferr0), 32'd1);
    checkVal("repStartDrained", 32'(expQ.size()), 32'd0);

    // Reset while driving ACK.
    setReady(1'b0);
    ferr0 = ferrCnt;
    busStart();
    sendWord(32'h0BADBEEF);
    sendByteBits(8'h42);
    checkVal("ackDriveBeforeRst", 32'(SdaPullLow), 32'd1);
    reset = 1'b1;
    waitClk(1);
    checkVal("rstMidSdaPullLow", 32'(SdaPullLow), 32'd0);
    checkVal("rstMidValid", 32'(RxValid), 32'd0);
    checkVal("rstMidBusy", 32'(BusBusy), 32'd0);
    reset = 1'b0;
    expQ.delete();
    waitClk(PH / 2);
    sclDrv = 1'b0;
    waitClk(2);
    busStop();
    checkVal("rstMidNoFrameErr", 32'(ferrCnt - ferr0), 32'd0);
    setReady(1'b1);
    waitClk(10);
    checkVal("rstMidStillEmpty", 32'(RxValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
